// File: rtl/sap_control_sequencer_pkg.sv
// Shared SAP-1 constants: opcodes, control-word bit positions, T-state indices
// and the microcode ROM output record.
package sap_pkg;
  localparam int CON_W = 12;
  localparam int CON_CP = 11;
  localparam int CON_EP = 10;
  localparam int CON_LM = 9;
  localparam int CON_CE = 8;
  localparam int CON_LI = 7;
  localparam int CON_EI = 6;
  localparam int CON_LA = 5;
  localparam int CON_EA = 4;
  localparam int CON_SU = 3;
  localparam int CON_EU = 2;
  localparam int CON_LB = 1;
  localparam int CON_LO = 0;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'he;
  localparam logic [3:0] OP_HLT = 4'hf;

  localparam int T_W = 6;
  localparam int T1 = 0;
  localparam int T2 = 1;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 4;
  localparam int T6 = 5;

  typedef logic [CON_W-1:0] con_t;

  typedef struct packed {
    con_t con;
    logic last_state;
    logic is_hlt;
    logic is_illegal;
  } ucode_t;

  function automatic logic is_onehot(input logic [T_W-1:0] v);
    return (v != '0) && ((v & (v - T_W'(1))) == '0);
  endfunction
endpackage

// File: rtl/sap_control_sequencer_if.sv
// Ring-counter/IR side <-> sequencer bundle. master drives t/opcode, slave is the sequencer.
interface sap_control_sequencer_if #(parameter int CNT_W = 8);
  import sap_pkg::*;

  logic [T_W-1:0]   t;
  logic [3:0]       opcode;
  logic [CON_W-1:0] con;
  logic             hlt;
  logic             ring_rst;
  logic             illegal;
  logic             t_err;
  logic [CNT_W-1:0] retired;

  modport master (output t, opcode,
                  input  con, hlt, ring_rst, illegal, t_err, retired);
  modport slave  (input  t, opcode,
                  output con, hlt, ring_rst, illegal, t_err, retired);
endinterface

// File: rtl/sap_control_sequencer_ucode_rom.sv
// Pure combinational microcode: {t, opcode} -> control word plus instruction-end/HLT/illegal markers.
module sap_ucode_rom import sap_pkg::*; #(
  parameter bit EARLY_END = 1'b1
) (
  input  logic [T_W-1:0] t,
  input  logic [3:0]     opcode,
  output ucode_t         uc
);
  always_comb begin
    uc = '0;
    if (t[T1]) begin
      uc.con[CON_EP] = 1'b1;
      uc.con[CON_LM] = 1'b1;
    end else if (t[T2]) begin
      uc.con[CON_CP] = 1'b1;
    end else if (t[T3]) begin
      uc.con[CON_CE] = 1'b1;
      uc.con[CON_LI] = 1'b1;
    end else begin
      // Execute phase: opcode is only trusted from T4 on
      case (opcode)
        OP_LDA: begin
          if (t[T4]) begin
            uc.con[CON_EI] = 1'b1;
            uc.con[CON_LM] = 1'b1;
          end else if (t[T5]) begin
            uc.con[CON_CE] = 1'b1;
            uc.con[CON_LA] = 1'b1;
          end
          uc.last_state = EARLY_END ? t[T5] : t[T6];
        end
        OP_ADD, OP_SUB: begin
          if (t[T4]) begin
            uc.con[CON_EI] = 1'b1;
            uc.con[CON_LM] = 1'b1;
          end else if (t[T5]) begin
            uc.con[CON_CE] = 1'b1;
            uc.con[CON_LB] = 1'b1;
          end else if (t[T6]) begin
            uc.con[CON_LA] = 1'b1;
            uc.con[CON_EU] = 1'b1;
            uc.con[CON_SU] = (opcode == OP_SUB);
          end
          uc.last_state = t[T6];
        end
        OP_OUT: begin
          if (t[T4]) begin
            uc.con[CON_EA] = 1'b1;
            uc.con[CON_LO] = 1'b1;
          end
          uc.last_state = EARLY_END ? t[T4] : t[T6];
        end
        OP_HLT: begin
          // HLT never retires, so it never marks a last state
          uc.is_hlt = t[T4];
        end
        default: begin
          uc.is_illegal = t[T4];
          uc.last_state = EARLY_END ? t[T4] : t[T6];
        end
      endcase
    end
  end
endmodule

// File: rtl/sap_control_sequencer.sv
// SAP-1 control sequencer: gates the microcode word, keeps sticky halt/illegal/t_err
// flags, requests early ring-counter restart and counts retired instructions.
module sap_control_sequencer import sap_pkg::*; #(
  parameter bit EARLY_END = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic                    clk,
  input  logic                    res,
  sap_control_sequencer_if.slave  bus
);
  ucode_t           uc;
  logic             onehot;
  logic             active;
  logic             hlt_q;
  logic             illegal_q;
  logic             t_err_q;
  logic [CNT_W-1:0] retired_q;

  sap_ucode_rom #(.EARLY_END(EARLY_END)) u_rom (
    .t      (bus.t),
    .opcode (bus.opcode),
    .uc     (uc)
  );

  // A bad t vector suppresses outputs in the same cycle it is seen
  assign onehot = is_onehot(bus.t);
  assign active = !res && !hlt_q && !t_err_q && onehot;

  assign bus.con      = active ? uc.con : '0;
  // T6 wraps naturally in the ring counter, so only shorter endings need a request
  assign bus.ring_rst = EARLY_END && active && uc.last_state && !bus.t[T6];
  assign bus.hlt      = hlt_q;
  assign bus.illegal  = illegal_q;
  assign bus.t_err    = t_err_q;
  assign bus.retired  = retired_q;

  always_ff @(posedge clk) begin
    if (res) begin
      hlt_q     <= 1'b0;
      illegal_q <= 1'b0;
      t_err_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      if (!onehot)                   t_err_q   <= 1'b1;
      if (active && uc.is_hlt)       hlt_q     <= 1'b1;
      if (active && uc.is_illegal)   illegal_q <= 1'b1;
      if (active && uc.last_state)   retired_q <= retired_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_sap_control_sequencer.sv
// Vector-table bench for the SAP-1 control sequencer; three DUTs share one stimulus
// stream (default, 2-bit counter, EARLY_END=0).
module tb_sap_control_sequencer;
  import sap_pkg::*;

  localparam logic [5:0] S1 = 6'b000001, S2 = 6'b000010, S3 = 6'b000100;
  localparam logic [5:0] S4 = 6'b001000, S5 = 6'b010000, S6 = 6'b100000;
  // Control words from bit order {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
  localparam logic [11:0] C_F1 = 12'h600, C_F2 = 12'h800, C_F3 = 12'h180;
  localparam logic [11:0] C_EX4 = 12'h240, C_LDA5 = 12'h120, C_ALU5 = 12'h102;
  localparam logic [11:0] C_ADD6 = 12'h024, C_SUB6 = 12'h02c, C_OUT4 = 12'h011;

  typedef struct {
    logic        res;
    logic [5:0]  t;
    logic [3:0]  op;
    logic [11:0] con;
    logic        rr;
    logic        hlt;
    logic        ill;
    logic        terr;
    logic [7:0]  ret;
  } vec_t;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic [5:0] t   = S1;
  logic [3:0] op  = 4'h0;

  int checks = 0;
  int failures = 0;
  int vi = 0;
  vec_t tbl[$];
  vec_t sb[$];

  sap_control_sequencer_if #(.CNT_W(8)) bus_a ();
  sap_control_sequencer_if #(.CNT_W(2)) bus_b ();
  sap_control_sequencer_if #(.CNT_W(8)) bus_c ();

  assign bus_a.t = t;  assign bus_a.opcode = op;
  assign bus_b.t = t;  assign bus_b.opcode = op;
  assign bus_c.t = t;  assign bus_c.opcode = op;

  sap_control_sequencer #(.EARLY_END(1'b1), .CNT_W(8)) dut_a (.clk(clk), .res(res), .bus(bus_a));
  sap_control_sequencer #(.EARLY_END(1'b1), .CNT_W(2)) dut_b (.clk(clk), .res(res), .bus(bus_b));
  sap_control_sequencer #(.EARLY_END(1'b0), .CNT_W(8)) dut_c (.clk(clk), .res(res), .bus(bus_c));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic r, input logic [5:0] tt, input logic [3:0] o,
                              input logic [11:0] c, input logic rr, input logic h,
                              input logic il, input logic te, input logic [7:0] rt);
    vec_t v;
    v.res = r; v.t = tt; v.op = o; v.con = c; v.rr = rr;
    v.hlt = h; v.ill = il; v.terr = te; v.ret = rt;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, vi, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(posedge clk);
    #1;
    res = v.res; t = v.t; op = v.op;
    sb.push_back(v);
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty vec=%0d", vi);
    end else begin
      e = sb.pop_front();
      cmp("con",       32'(bus_a.con),      32'(e.con));
      cmp("ring_rst",  32'(bus_a.ring_rst), 32'(e.rr));
      cmp("hlt",       32'(bus_a.hlt),      32'(e.hlt));
      cmp("illegal",   32'(bus_a.illegal),  32'(e.ill));
      cmp("t_err",     32'(bus_a.t_err),    32'(e.terr));
      cmp("retired",   32'(bus_a.retired),  32'(e.ret));
      cmp("retired_w2", 32'(bus_b.retired), 32'(e.ret[1:0]));
      cmp("con_noearly", 32'(bus_c.con),    32'(e.con));
      cmp("ring_rst_noearly", 32'(bus_c.ring_rst), 32'd0);
    end
    vi++;
  endtask

  initial begin
    logic [5:0] one;
    // reset
    tbl.push_back(mk(1, S1, 4'h0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, S1, 4'h0, 0, 0, 0, 0, 0, 0));
    // ADD
    tbl.push_back(mk(0, S1, OP_ADD, C_F1,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, S2, OP_ADD, C_F2,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, S3, OP_ADD, C_F3,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, S4, OP_ADD, C_EX4,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, S5, OP_ADD, C_ALU5, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, S6, OP_ADD, C_ADD6, 0, 0, 0, 0, 0));
    // OUT ends at T4
    tbl.push_back(mk(0, S1, OP_OUT, C_F1,   0, 0, 0, 0, 1));
    tbl.push_back(mk(0, S2, OP_OUT, C_F2,   0, 0, 0, 0, 1));
    tbl.push_back(mk(0, S3, OP_OUT, C_F3,   0, 0, 0, 0, 1));
    tbl.push_back(mk(0, S4, OP_OUT, C_OUT4, 1, 0, 0, 0, 1));
    // LDA ends at T5
    tbl.push_back(mk(0, S1, OP_LDA, C_F1,   0, 0, 0, 0, 2));
    tbl.push_back(mk(0, S2, OP_LDA, C_F2,   0, 0, 0, 0, 2));
    tbl.push_back(mk(0, S3, OP_LDA, C_F3,   0, 0, 0, 0, 2));
    tbl.push_back(mk(0, S4, OP_LDA, C_EX4,  0, 0, 0, 0, 2));
    tbl.push_back(mk(0, S5, OP_LDA, C_LDA5, 1, 0, 0, 0, 2));
    // SUB
    tbl.push_back(mk(0, S1, OP_SUB, C_F1,   0, 0, 0, 0, 3));
    tbl.push_back(mk(0, S2, OP_SUB, C_F2,   0, 0, 0, 0, 3));
    tbl.push_back(mk(0, S3, OP_SUB, C_F3,   0, 0, 0, 0, 3));
    tbl.push_back(mk(0, S4, OP_SUB, C_EX4,  0, 0, 0, 0, 3));
    tbl.push_back(mk(0, S5, OP_SUB, C_ALU5, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, S6, OP_SUB, C_SUB6, 0, 0, 0, 0, 3));
    // undefined opcode 0101
    tbl.push_back(mk(0, S1, 4'h5, C_F1, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, S2, 4'h5, C_F2, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, S3, 4'h5, C_F3, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, S4, 4'h5, 0,    1, 0, 0, 0, 4));
    // HLT
    tbl.push_back(mk(0, S1, OP_HLT, C_F1, 0, 0, 1, 0, 5));
    tbl.push_back(mk(0, S2, OP_HLT, C_F2, 0, 0, 1, 0, 5));
    tbl.push_back(mk(0, S3, OP_HLT, C_F3, 0, 0, 1, 0, 5));
    tbl.push_back(mk(0, S4, OP_HLT, 0,    0, 0, 1, 0, 5));
    tbl.push_back(mk(0, S5, OP_HLT, 0,    0, 1, 1, 0, 5));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // halted: ten cycles of live-looking stimulus must do nothing
    for (int i = 0; i < 10; i++) begin
      one = 6'b000001;
      one = one << (i % 6);
      apply(mk(0, one, (i % 2 == 1) ? OP_OUT : OP_LDA, 0, 0, 1, 1, 0, 5));
    end
    apply(mk(1, S1, OP_LDA, 0,    0, 1, 1, 0, 5));
    apply(mk(0, S1, OP_ADD, C_F1, 0, 0, 0, 0, 0));

    // reset mid-instruction aborts with no retire
    apply(mk(0, S2, OP_ADD, C_F2,   0, 0, 0, 0, 0));
    apply(mk(0, S3, OP_ADD, C_F3,   0, 0, 0, 0, 0));
    apply(mk(0, S4, OP_ADD, C_EX4,  0, 0, 0, 0, 0));
    apply(mk(0, S5, OP_ADD, C_ALU5, 0, 0, 0, 0, 0));
    apply(mk(1, S6, OP_ADD, 0,      0, 0, 0, 0, 0));
    apply(mk(0, S1, OP_ADD, C_F1,   0, 0, 0, 0, 0));

    // reset beats a bad t vector
    apply(mk(1, 6'b000011, OP_LDA, 0,    0, 0, 0, 0, 0));
    apply(mk(0, S1,        OP_LDA, C_F1, 0, 0, 0, 0, 0));

    // t not one-hot: outputs dead the same cycle, flag next
    apply(mk(0, 6'b000011, OP_LDA, 0, 0, 0, 0, 0, 0));
    apply(mk(0, S2,        OP_LDA, 0, 0, 0, 0, 1, 0));
    apply(mk(0, S5,        OP_LDA, 0, 0, 0, 0, 1, 0));
    apply(mk(1, S1,        OP_LDA, 0, 0, 0, 0, 1, 0));
    apply(mk(0, 6'b000000, OP_LDA, 0, 0, 0, 0, 0, 0));
    apply(mk(0, S1,        OP_LDA, 0, 0, 0, 0, 1, 0));
    apply(mk(1, S1,        OP_LDA, 0, 0, 0, 0, 1, 0));

    // four LDAs from reset: 2-bit counter wraps to 0
    for (int k = 0; k < 4; k++) begin
      apply(mk(0, S1, OP_LDA, C_F1,   0, 0, 0, 0, 8'(k)));
      apply(mk(0, S2, OP_LDA, C_F2,   0, 0, 0, 0, 8'(k)));
      apply(mk(0, S3, OP_LDA, C_F3,   0, 0, 0, 0, 8'(k)));
      apply(mk(0, S4, OP_LDA, C_EX4,  0, 0, 0, 0, 8'(k)));
      apply(mk(0, S5, OP_LDA, C_LDA5, 1, 0, 0, 0, 8'(k)));
    end
    apply(mk(0, S1, OP_LDA, C_F1, 0, 0, 0, 0, 4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
